echo_gate_peak: RTL and testbench

Per-burst echo evaluator for the EMAT receive path. It sits downstream of the AD9246 capture logic, in parallel with the FIFO write path, and sees each sample as it is written to the FIFO. Within an ARM-programmed gate window it finds the peak rectified amplitude and its sample index, compares the peak against a threshold, and drives the ARM result registers and the buzzer alarm request.

---
 rtl/echo_gate_pkg.sv | 30 +++
 rtl/echo_rectify.sv | 63 ++++++
 rtl/echo_gate_peak.sv | 232 +++++++++++++++++++++++
 tb/tb_echo_gate_peak.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_gate_pkg.sv
`default_nettype none
//==============================================================================
// Module      : echo_gate_pkg
// Description : Shared definitions for the echo gate peak evaluator: default
//               sample/index widths, the gate FSM state type and the
//               offset-binary midscale constant.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package echo_gate_pkg;

   localparam int DW_DEFAULT = 14;   // ADC sample width
   localparam int CW_DEFAULT = 16;   // sample index / gate counter width

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      IN_GATE = 2'd2,
      DONE    = 2'd3
   } gate_state_t;

   // 2^(dw-1): the offset-binary code that represents zero volts
   function automatic int unsigned midscale(input int unsigned dw);
      return 32'd1 << (dw - 1);
   endfunction

   localparam int unsigned c_midscale = midscale(DW_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/echo_rectify.sv
`default_nettype none
//==============================================================================
// Module      : echo_rectify
// Description : Registered offset-binary to magnitude conversion. The sample
//               valid strobe and sample index travel alongside the magnitude
//               so downstream logic sees all three aligned.
// Ports       : clk_sys, RESET_N (sync, active-low)
//               i_valid/i_data/i_idx  - raw sample, code and index
//               o_valid/o_mag/o_idx   - one cycle later: magnitude and index
// Revision    : 1.0 - initial release
//==============================================================================
module echo_rectify
   import echo_gate_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk_sys,
   input  logic          RESET_N,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   input  logic [CW-1:0] i_idx,
   output logic          o_valid,
   output logic [DW-2:0] o_mag,
   output logic [CW-1:0] o_idx
);

   localparam logic [DW-1:0] c_mid    = DW'(midscale(DW));
   localparam logic [DW-1:0] c_mid_m1 = c_mid - DW'(1);

   logic [DW-1:0] w_mag_full;
   logic          w_unused_msb;
   logic          r_valid;
   logic [DW-2:0] r_mag;
   logic [CW-1:0] r_idx;

   // Upper half: code - mid. Lower half: (mid-1) - code. Both fit in DW-1 bits,
   // so the top bit of the DW-wide result is always zero.
   always_comb begin
      w_mag_full = i_data[DW-1] ? (i_data - c_mid) : (c_mid_m1 - i_data);
   end
   assign w_unused_msb = w_mag_full[DW-1];

   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_valid <= 1'b0;
         r_mag   <= '0;
         r_idx   <= '0;
      end else begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_mag <= w_mag_full[DW-2:0];
            r_idx <= i_idx;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_mag   = r_mag;
   assign o_idx   = r_idx;

endmodule
`default_nettype wire

// File: rtl/echo_gate_peak.sv
`default_nettype none
//==============================================================================
// Module      : echo_gate_peak
// Description : Per-burst echo evaluator. Tracks the peak rectified amplitude
//               and its sample index inside a programmable gate window,
//               reports it once per burst and raises a threshold alarm.
// Build macro : ECHO_ALARM_LATCH_EN - when defined, gate_alarm is sticky until
//               alarm_clr; otherwise it follows the last completed gate.
// Ports       : clk_sys, RESET_N (sync, active-low)
//               i_burst_syn     - burst start pulse (restarts / aborts)
//               i_AD_sample_en  - acquisition window; falling edge ends gate
//               i_sample_valid/i_sample_data - ADC sample strobe and code
//               i_gate_start/i_gate_width    - gate, latched at burst start
//               i_threshold     - alarm threshold on magnitude
//               i_alarm_clr     - clear of the sticky alarm
//               o_peak_amp/o_peak_pos - result of last completed gate
//               o_result_valid  - one-cycle result pulse
//               o_gate_alarm    - alarm request
//               o_busy          - burst in progress
// Revision    : 1.0 - initial release
//==============================================================================
module echo_gate_peak
   import echo_gate_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk_sys,
   input  logic          RESET_N,
   input  logic          i_burst_syn,
   input  logic          i_AD_sample_en,
   input  logic          i_sample_valid,
   input  logic [DW-1:0] i_sample_data,
   input  logic [CW-1:0] i_gate_start,
   input  logic [CW-1:0] i_gate_width,
   input  logic [DW-2:0] i_threshold,
   input  logic          i_alarm_clr,
   output logic [DW-2:0] o_peak_amp,
   output logic [CW-1:0] o_peak_pos,
   output logic          o_result_valid,
   output logic          o_gate_alarm,
   output logic          o_busy
);

   gate_state_t   r_state;
   gate_state_t   w_next_state;
   logic          w_load;

   logic [CW-1:0] r_idx;
   logic [CW-1:0] r_gate_start;
   logic [CW:0]   r_gate_end;
   logic          r_gate_zero;
   logic          r_en_d;
   logic          r_fall;

   logic          w_accept;
   logic          w_rect_valid;
   logic [DW-2:0] w_rect_mag;
   logic [CW-1:0] w_rect_idx;
   logic          w_in_gate;
   logic          w_last;
   logic          w_track;
   logic          w_upd;
   logic [DW-2:0] w_new_max;
   logic [CW-1:0] w_new_pos;
   logic          w_hit;

   logic [DW-2:0] r_max;
   logic [CW-1:0] r_pos;
   logic [DW-2:0] r_peak_amp;
   logic [CW-1:0] r_peak_pos;
   logic          r_alarm;

   // A sample coinciding with burst_syn belongs to neither burst.
   assign w_accept = i_sample_valid & i_AD_sample_en & ~i_burst_syn;

   // Sample index counter and burst-latched gate parameters
   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_idx        <= '0;
         r_gate_start <= '0;
         r_gate_end   <= '0;
         r_gate_zero  <= 1'b0;
      end else if (i_burst_syn) begin
         r_idx        <= '0;
         r_gate_start <= i_gate_start;
         r_gate_end   <= {1'b0, i_gate_start} + {1'b0, i_gate_width};
         r_gate_zero  <= (i_gate_width == '0);
      end else if (w_accept && (r_idx != '1)) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   // The falling edge is delayed one cycle so it lines up with the rectifier
   // stage: the last sample before the edge is already in r_max when we act.
   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_en_d <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_en_d <= i_AD_sample_en;
         r_fall <= r_en_d & ~i_AD_sample_en;
      end
   end

   echo_rectify #(
      .DW (DW),
      .CW (CW)
   ) u_rectify (
      .clk_sys (clk_sys),
      .RESET_N (RESET_N),
      .i_valid (w_accept),
      .i_data  (i_sample_data),
      .i_idx   (r_idx),
      .o_valid (w_rect_valid),
      .o_mag   (w_rect_mag),
      .o_idx   (w_rect_idx)
   );

   // gate_end is CW+1 bits wide, so a gate running past the counter range
   // never wraps to a small end value.
   assign w_in_gate = w_rect_valid
                    && (w_rect_idx >= r_gate_start)
                    && ({1'b0, w_rect_idx} < r_gate_end);
   assign w_last    = w_in_gate
                    && ({1'b0, w_rect_idx} == (r_gate_end - {{CW{1'b0}}, 1'b1}));
   assign w_track   = ((r_state == ARMED) || (r_state == IN_GATE)) && w_in_gate;
   assign w_upd     = w_track && (w_rect_mag > r_max);   // strict: ties keep first
   assign w_new_max = w_upd ? w_rect_mag : r_max;
   assign w_new_pos = w_upd ? w_rect_idx : r_pos;

   // FSM state register
   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next state; w_load marks the transition into DONE where the result
   // registers capture the max including any sample in the rectifier stage.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_burst_syn) w_next_state = ARMED;
         end
         ARMED: begin
            if (i_burst_syn) begin
               w_next_state = ARMED;
            end else if (r_gate_zero || w_last || r_fall) begin
               // a one-sample gate completes without visiting IN_GATE
               w_next_state = DONE;
            end else if (w_in_gate) begin
               w_next_state = IN_GATE;
            end
         end
         IN_GATE: begin
            if (i_burst_syn) begin
               w_next_state = ARMED;
            end else if (w_last || r_fall) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_next_state = i_burst_syn ? ARMED : IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
      if (w_next_state == DONE) w_load = 1'b1;
   end

   assign w_hit = w_load && !r_gate_zero && (w_new_max >= i_threshold);

   // Running max, result registers and alarm
   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_max      <= '0;
         r_pos      <= '0;
         r_peak_amp <= '0;
         r_peak_pos <= '0;
      end else begin
         if (i_burst_syn) begin
            r_max <= '0;
            r_pos <= '0;
         end else if (w_upd) begin
            r_max <= w_rect_mag;
            r_pos <= w_rect_idx;
         end
         if (w_load) begin
            r_peak_amp <= w_new_max;
            r_peak_pos <= w_new_pos;
         end
      end
   end

`ifdef ECHO_ALARM_LATCH_EN
   // Sticky alarm: a new alarm beats a simultaneous clear.
   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_alarm <= 1'b0;
      end else if (w_hit) begin
         r_alarm <= 1'b1;
      end else if (i_alarm_clr) begin
         r_alarm <= 1'b0;
      end
   end
`else
   logic w_unused_clr;
   assign w_unused_clr = i_alarm_clr;

   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         r_alarm <= 1'b0;
      end else if (w_load) begin
         r_alarm <= w_hit;
      end
   end
`endif

   assign o_peak_amp     = r_peak_amp;
   assign o_peak_pos     = r_peak_pos;
   assign o_result_valid = (r_state == DONE);
   assign o_gate_alarm   = r_alarm;
   assign o_busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_echo_gate_peak.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_echo_gate_peak
// Description : Self-checking bench for echo_gate_peak with a behavioural
//               peak/alarm model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_echo_gate_peak;

   localparam int DW = 14;
   localparam int CW = 16;

   logic          clk_sys = 1'b0;
   logic          RESET_N = 1'b0;
   logic          i_burst_syn = 1'b0;
   logic          i_AD_sample_en = 1'b0;
   logic          i_sample_valid = 1'b0;
   logic [DW-1:0] i_sample_data = '0;
   logic [CW-1:0] i_gate_start = '0;
   logic [CW-1:0] i_gate_width = '0;
   logic [DW-2:0] i_threshold = '0;
   logic          i_alarm_clr = 1'b0;
   logic [DW-2:0] o_peak_amp;
   logic [CW-1:0] o_peak_pos;
   logic          o_result_valid;
   logic          o_gate_alarm;
   logic          o_busy;

   echo_gate_peak #(.DW(DW), .CW(CW)) dut (
      .clk_sys        (clk_sys),
      .RESET_N        (RESET_N),
      .i_burst_syn    (i_burst_syn),
      .i_AD_sample_en (i_AD_sample_en),
      .i_sample_valid (i_sample_valid),
      .i_sample_data  (i_sample_data),
      .i_gate_start   (i_gate_start),
      .i_gate_width   (i_gate_width),
      .i_threshold    (i_threshold),
      .i_alarm_clr    (i_alarm_clr),
      .o_peak_amp     (o_peak_amp),
      .o_peak_pos     (o_peak_pos),
      .o_result_valid (o_result_valid),
      .o_gate_alarm   (o_gate_alarm),
      .o_busy         (o_busy)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   int           rv_count = 0;
   int           rv_cyc = -10;
   logic [12:0]  rv_amp = '0;
   logic [15:0]  rv_pos = '0;
   logic         rv_alarm = 1'b0;
   logic         rv_busy_after = 1'b0;

   always @(negedge clk_sys) begin
      if (o_result_valid === 1'b1) begin
         rv_count <= rv_count + 1;
         rv_cyc   <= cyc;
         rv_amp   <= o_peak_amp;
         rv_pos   <= o_peak_pos;
         rv_alarm <= o_gate_alarm;
      end
      if (rv_count > 0 && cyc == rv_cyc + 1) rv_busy_after <= o_busy;
   end

   int tests = 0;
   int fails = 0;
   int codes[$];
   bit exp_alarm = 1'b0;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic int mag_of(input int code);
      return (code >= 8192) ? (code - 8192) : (8191 - code);
   endfunction

   task automatic fill_ramp(input int n);
      codes.delete();
      for (int k = 0; k < n; k++) codes.push_back(8192 + k);
   endtask

   task automatic fill_random(input int n);
      codes.delete();
      for (int k = 0; k < n; k++) codes.push_back(int'($urandom_range(0, 16383)));
   endtask

   // Full burst: burst_syn, every code in `codes`, then AD_sample_en falls.
   task automatic run_burst(input string name, input int gs, input int gw, input int thr,
                            input bit gaps, input bit clr_hold);
      int n, gend, b_cyc, last_cyc, f_cyc, exp_cyc, exp_amp, exp_pos, c0;
      bit complete, hit, exp_at_res;
      n = codes.size();
      gend = gs + gw;
      exp_amp = 0;
      exp_pos = 0;
      last_cyc = -1;
      for (int k = gs; k < gend && k < n; k++) begin
         if (mag_of(codes[k]) > exp_amp) begin
            exp_amp = mag_of(codes[k]);
            exp_pos = k;
         end
      end
      complete = (gw != 0) && (gend <= n);
      hit = (gw != 0) && (exp_amp >= thr);
`ifdef ECHO_ALARM_LATCH_EN
      exp_at_res = hit ? 1'b1 : (clr_hold ? 1'b0 : exp_alarm);
      exp_alarm  = clr_hold ? 1'b0 : exp_at_res;
`else
      exp_at_res = hit;
      exp_alarm  = hit;
`endif
      c0 = rv_count;
      i_gate_start   = CW'(gs);
      i_gate_width   = CW'(gw);
      i_threshold    = (DW-1)'(thr);
      i_alarm_clr    = clr_hold;
      i_burst_syn    = 1'b1;
      i_AD_sample_en = 1'b1;
      i_sample_valid = 1'b0;
      b_cyc = cyc;
      step();
      i_burst_syn = 1'b0;
      @(negedge clk_sys);
      tests++;
      if (o_busy !== 1'b1) begin
         fails++;
         $display("FAIL %s busy_rise: got %b want 1", name, o_busy);
      end
      for (int k = 0; k < n; k++) begin
         if (gaps) begin
            int g;
            g = int'($urandom_range(0, 2));
            for (int j = 0; j < g; j++) begin
               i_sample_valid = 1'b0;
               i_sample_data  = DW'($urandom);
               step();
            end
         end
         i_sample_valid = 1'b1;
         i_sample_data  = DW'(codes[k]);
         if (k == gend - 1) last_cyc = cyc;
         step();
      end
      i_sample_valid = 1'b0;
      i_AD_sample_en = 1'b0;
      f_cyc = cyc;
      repeat (6) step();
      exp_cyc = (gw == 0) ? (b_cyc + 2) : (complete ? (last_cyc + 2) : (f_cyc + 2));
      @(negedge clk_sys);
      tests++;
      if (rv_count - c0 != 1) begin
         fails++;
         $display("FAIL %s result_count: got %0d want 1", name, rv_count - c0);
      end else begin
         tests += 5;
         if (rv_cyc != exp_cyc) begin
            fails++;
            $display("FAIL %s result_cycle: got %0d want %0d", name, rv_cyc, exp_cyc);
         end
         if (int'(rv_amp) != exp_amp) begin
            fails++;
            $display("FAIL %s peak_amp: got %0d want %0d", name, rv_amp, exp_amp);
         end
         if (int'(rv_pos) != exp_pos) begin
            fails++;
            $display("FAIL %s peak_pos: got %0d want %0d", name, rv_pos, exp_pos);
         end
         if (rv_alarm !== exp_at_res) begin
            fails++;
            $display("FAIL %s alarm_at_result: got %b want %b", name, rv_alarm, exp_at_res);
         end
         if (rv_busy_after !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_fall: got %b want 0", name, rv_busy_after);
         end
      end
      tests++;
      if (o_gate_alarm !== exp_alarm) begin
         fails++;
         $display("FAIL %s alarm_after: got %b want %b", name, o_gate_alarm, exp_alarm);
      end
      i_alarm_clr = 1'b0;
      step();
   endtask

   // Burst start plus n samples; the burst is left open.
   task automatic feed_partial(input int gs, input int gw, input int thr, input int n);
      i_gate_start   = CW'(gs);
      i_gate_width   = CW'(gw);
      i_threshold    = (DW-1)'(thr);
      i_burst_syn    = 1'b1;
      i_AD_sample_en = 1'b1;
      step();
      i_burst_syn = 1'b0;
      for (int k = 0; k < n; k++) begin
         i_sample_valid = 1'b1;
         i_sample_data  = DW'(codes[k]);
         step();
      end
      i_sample_valid = 1'b0;
   endtask

   task automatic pulse_clr(input string name);
      i_alarm_clr = 1'b1;
      step();
      i_alarm_clr = 1'b0;
`ifdef ECHO_ALARM_LATCH_EN
      exp_alarm = 1'b0;
`endif
      step();
      @(negedge clk_sys);
      tests++;
      if (o_gate_alarm !== exp_alarm) begin
         fails++;
         $display("FAIL %s alarm_clr: got %b want %b", name, o_gate_alarm, exp_alarm);
      end
      step();
   endtask

   task automatic check_idle_outputs(input string name);
      @(negedge clk_sys);
      tests += 5;
      if (o_peak_amp !== '0) begin fails++; $display("FAIL %s peak_amp: got %0d want 0", name, o_peak_amp); end
      if (o_peak_pos !== '0) begin fails++; $display("FAIL %s peak_pos: got %0d want 0", name, o_peak_pos); end
      if (o_result_valid !== 1'b0) begin fails++; $display("FAIL %s result_valid: got %b want 0", name, o_result_valid); end
      if (o_gate_alarm !== 1'b0) begin fails++; $display("FAIL %s gate_alarm: got %b want 0", name, o_gate_alarm); end
      if (o_busy !== 1'b0) begin fails++; $display("FAIL %s busy: got %b want 0", name, o_busy); end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      repeat (3) step();
      RESET_N = 1'b1;
      step();
      check_idle_outputs("reset");
      step();
   endtask

   task automatic test_basic();
      fill_ramp(160);
      codes[120] = 12000;
      run_burst("basic", 100, 50, 4000, 1'b1, 1'b0);
   endtask

   task automatic test_alarm();
      fill_ramp(160);
      codes[120] = 12000;
      codes[130] = 0;
      run_burst("alarm", 100, 50, 4000, 1'b1, 1'b0);
      fill_ramp(160);
      codes[120] = 12000;
      run_burst("alarm_clean", 100, 50, 4000, 1'b1, 1'b0);
      pulse_clr("alarm_clr1");
      fill_ramp(160);
      codes[130] = 0;
      run_burst("alarm_set_wins", 100, 50, 4000, 1'b1, 1'b1);
      fill_ramp(160);
      codes[130] = 0;
      run_burst("alarm_again", 100, 50, 4000, 1'b0, 1'b0);
      pulse_clr("alarm_clr2");
   endtask

   task automatic test_tie_boundary();
      codes.delete();
      for (int k = 0; k < 170; k++) codes.push_back(8192 + int'($urandom_range(0, 500)));
      codes[100] = 9000;
      codes[149] = 9000;
      codes[150] = 10000;
      run_burst("tie", 100, 50, 4000, 1'b1, 1'b0);
   endtask

   task automatic test_zero_width();
      fill_random(20);
      run_burst("zero_width", 5, 0, 1, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      int c0;
      c0 = rv_count;
      fill_ramp(121);
      codes[110] = 0;
      feed_partial(100, 50, 4000, 121);
      fill_ramp(160);
      codes[140] = 11000;
      run_burst("abort_new", 100, 50, 4000, 1'b0, 1'b0);
      tests++;
      if (rv_count != c0 + 1) begin
         fails++;
         $display("FAIL abort result_count: got %0d want %0d", rv_count - c0, 1);
      end
   endtask

   task automatic test_reset_mid();
      int c0;
      fill_ramp(160);
      codes[105] = 0;
      run_burst("pre_reset", 100, 50, 4000, 1'b0, 1'b0);
      feed_partial(100, 50, 4000, 111);
      c0 = rv_count;
      RESET_N = 1'b0;
      step();
      RESET_N = 1'b1;
      exp_alarm = 1'b0;
      check_idle_outputs("reset_mid");
      for (int k = 111; k < 160; k++) begin
         i_sample_valid = 1'b1;
         i_sample_data  = DW'(codes[k]);
         step();
      end
      i_sample_valid = 1'b0;
      i_AD_sample_en = 1'b0;
      repeat (6) step();
      tests++;
      if (rv_count != c0) begin
         fails++;
         $display("FAIL reset_mid no_result: got %0d results want 0", rv_count - c0);
      end
      fill_ramp(160);
      codes[101] = 3000;
      run_burst("post_reset", 100, 50, 4000, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int b = 0; b < 10; b++) begin
         fill_random(int'($urandom_range(0, 90)));
         run_burst($sformatf("random%0d", b), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 40)), int'($urandom_range(3000, 8191)),
                   1'b1, 1'(b % 3 == 0));
      end
   endtask

   task automatic test_truncation();
      fill_random(62000);
      run_burst("truncation", 60000, 10000, int'($urandom_range(6000, 8191)), 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alarm();
      test_tie_boundary();
      test_zero_width();
      test_abort();
      test_reset_mid();
      test_random();
      test_truncation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
